// File: rtl/bumper_avoid_ctrl.sv
// bumper_avoid_ctrl: forward/reverse/pivot motor controller driven by two bumpers (optional BUMPER_DEBOUNCE_EN)
module bumper_avoid_ctrl #(
  parameter int CNT_W    = 24,
  parameter int BACK_CYC = 12000000,
  parameter int TURN_CYC = 8000000,
  parameter int DEB_CYC  = 250000,
  parameter int HIT_W    = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             run_i,
  input  logic             LeftBumper,
  input  logic             RightBumper,
  output logic             L_Ena,
  output logic             L_Dir,
  output logic             R_Ena,
  output logic             R_Dir,
  output logic             busy_o,
  output logic [1:0]       state_o,
  output logic [HIT_W-1:0] hits_o
);
  typedef enum logic [1:0] {STOP = 2'b00, FWD = 2'b01, REV = 2'b10, TURN = 2'b11} state_t;
  localparam logic [CNT_W-1:0] BACK_LAST = CNT_W'(BACK_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYC - 1);
  if (BACK_CYC < 1 || TURN_CYC < 1 || DEB_CYC < 1) begin : g_param_err
    $error("bumper_avoid_ctrl: BACK_CYC, TURN_CYC and DEB_CYC must be >= 1");
  end
  state_t           state, state_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic             side, side_n;
  logic [HIT_W-1:0] hits, hits_n;
  logic [1:0]       sync_l, sync_r;
  logic             hit_l, hit_r;
  // two-stage synchronisers; reset to the released (high) level so no phantom hit
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_l <= 2'b11;
      sync_r <= 2'b11;
    end else begin
      sync_l <= {sync_l[0], LeftBumper};
      sync_r <= {sync_r[0], RightBumper};
    end
  end
`ifdef BUMPER_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYC + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
  logic [DEB_W-1:0] deb_l, deb_r;
  logic             filt_l, filt_r;
  // filtered level only follows the synchroniser after DEB_CYC consecutive differing samples
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      deb_l  <= '0;
      deb_r  <= '0;
      filt_l <= 1'b1;
      filt_r <= 1'b1;
    end else begin
      deb_l  <= (sync_l[1] == filt_l || deb_l == DEB_LAST) ? '0 : deb_l + DEB_W'(1);
      deb_r  <= (sync_r[1] == filt_r || deb_r == DEB_LAST) ? '0 : deb_r + DEB_W'(1);
      filt_l <= (sync_l[1] != filt_l && deb_l == DEB_LAST) ? sync_l[1] : filt_l;
      filt_r <= (sync_r[1] != filt_r && deb_r == DEB_LAST) ? sync_r[1] : filt_r;
    end
  end
  assign hit_l = ~filt_l;
  assign hit_r = ~filt_r;
`else
  assign hit_l = ~sync_l[1];
  assign hit_r = ~sync_r[1];
`endif
  // state, manoeuvre timer, turn side and hit counter registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= STOP;
      timer <= '0;
      side  <= 1'b0;
      hits  <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      side  <= side_n;
      hits  <= hits_n;
    end
  end
  // next state: run_i low forces STOP; a hit in FWD starts reverse then pivot (side=1 pivots right)
  always_comb begin
    state_n = state;
    timer_n = '0;
    side_n  = side;
    hits_n  = hits;
    if (!run_i) state_n = STOP;
    else begin
      case (state)
        STOP: state_n = FWD;
        FWD: if (hit_l | hit_r) begin
          state_n = REV;
          side_n  = hit_l;
          hits_n  = &hits ? hits : hits + HIT_W'(1);
        end
        REV: begin
          state_n = timer == BACK_LAST ? TURN : REV;
          timer_n = timer == BACK_LAST ? '0 : timer + CNT_W'(1);
        end
        TURN: begin
          state_n = timer == TURN_LAST ? FWD : TURN;
          timer_n = timer == TURN_LAST ? '0 : timer + CNT_W'(1);
        end
        default: state_n = STOP;
      endcase
    end
  end
  assign L_Ena   = state == STOP;
  assign R_Ena   = state == STOP;
  assign L_Dir   = state == STOP || state == FWD || (state == TURN && side);
  assign R_Dir   = state == STOP || state == FWD || (state == TURN && !side);
  assign busy_o  = state[1];
  assign state_o = state;
  assign hits_o  = hits;
endmodule
